// File: rtl/dwa_element_rotator_if.sv
// DWA rotator handshake bundle.
// Master drives samples, slave returns element selects.
interface dwa_element_rotator_if #(
  parameter int N_ELEM = 15,
  parameter int PTR_W  = 4
);
  logic              sample_en;
  logic              dwa_en;
  logic [N_ELEM-1:0] therm_in;
  logic [N_ELEM-1:0] elem_out;
  logic [PTR_W-1:0]  ptr;
  logic              valid_out;
  logic              therm_err;

  modport master (
    output sample_en, dwa_en, therm_in,
    input  elem_out, ptr, valid_out, therm_err
  );

  modport slave (
    input  sample_en, dwa_en, therm_in,
    output elem_out, ptr, valid_out, therm_err
  );
endinterface

// File: rtl/dwa_element_rotator.sv
// DWA element rotator: maps a thermometer word onto
// unit DAC elements through a wrapping pointer.
module dwa_element_rotator #(
  parameter int N_ELEM = 15,
  parameter int PTR_W  = 4
) (
  input logic clk,
  input logic rst,
  dwa_element_rotator_if.slave bus
);

  localparam logic [PTR_W:0] NMOD = (PTR_W+1)'(N_ELEM);

  logic [N_ELEM-1:0] elem_q, elem_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              valid_q;
  logic              err_q;

  logic [PTR_W-1:0]  lvl;
  logic [N_ELEM-1:0] mask;
  logic [N_ELEM-1:0] rot;
  logic [PTR_W:0]    sum;
  logic [PTR_W-1:0]  ptr_wrap;
  logic              bad;

  // Level is the popcount, so bubbles still yield a usable k
  always_comb begin
    lvl = '0;
    for (int i = 0; i < N_ELEM; i++)
      lvl = lvl + PTR_W'(bus.therm_in[i]);
  end

  // Ideal thermometer of the same level, for bubble detection
  always_comb begin
    mask = '0;
    for (int i = 0; i < N_ELEM; i++)
      mask[i] = PTR_W'(i) < lvl;
    bad = bus.therm_in != mask;
  end

  // Element i is on when its distance past ptr is below k
  always_comb begin
    logic [PTR_W:0] off;
    off = '0;
    rot = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      if (PTR_W'(i) >= ptr_q)
        off = (PTR_W+1)'(i) - {1'b0, ptr_q};
      else
        off = (PTR_W+1)'(i) + NMOD - {1'b0, ptr_q};
      rot[i] = off < {1'b0, lvl};
    end
  end

  // Pointer advance mod N without a divider; k=N lands on ptr
  always_comb begin
    sum = {1'b0, ptr_q} + {1'b0, lvl};
    if (sum >= NMOD)
      ptr_wrap = PTR_W'(sum - NMOD);
    else
      ptr_wrap = PTR_W'(sum);
  end

  // Mode select: rotate, or pass thermometer straight through
  always_comb begin
    elem_d = bus.therm_in;
    ptr_d  = ptr_q;
    if (bus.dwa_en) begin
      elem_d = rot;
      ptr_d  = ptr_wrap;
    end
  end

  // Output and pointer registers, updated only on a sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_q  <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= bus.sample_en;
      err_q   <= bus.sample_en & bad;
      if (bus.sample_en) begin
        elem_q <= elem_d;
        ptr_q  <= ptr_d;
      end
    end
  end

  assign bus.elem_out  = elem_q;
  assign bus.ptr       = ptr_q;
  assign bus.valid_out = valid_q;
  assign bus.therm_err = err_q;

endmodule
